arb8_16b: RTL and testbench

ARB8_16B -- requirements
Module: arb8_16b

---
 rtl/arb8_16b.sv | 108 ++++++++++
 tb/tb_arb8_16b.sv | 132 +++++++++++++
 2 files changed

// File: rtl/arb8_16b.sv
// arb8_16b: 8-requester round-robin arbiter that registers the winning word and holds it until ready.
// Optional macro ARB8_LOCK_EN: lock at completion keeps the pointer on the current owner.
module arb8_16b #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         req,
  input  logic [8*WIDTH-1:0] data,
  input  logic               lock,
  input  logic               ready,
  output logic [7:0]         gnt,
  output logic [2:0]         sel,
  output logic [WIDTH-1:0]   out,
  output logic               out_valid,
  output logic [15:0]        xfer_cnt
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

`ifdef ARB8_LOCK_EN
  localparam bit LockEn = 1'b1;
`else
  localparam bit LockEn = 1'b0;
`endif

  state_t           r_state;
  state_t           w_stateNext;
  logic [2:0]       r_ptr;
  logic [7:0]       r_gnt;
  logic [2:0]       r_sel;
  logic [WIDTH-1:0] r_out;
  logic             r_outValid;
  logic [15:0]      r_xferCnt;

  logic             w_found;
  logic [2:0]       w_winner;
  logic             w_capture;
  logic             w_complete;
  logic [7:0]       w_gntNext;
  logic [2:0]       w_ptrNext;
  logic             w_lockHold;

  // Scan upward from ptr; the 3-bit add provides the 7 -> 0 wrap.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_ptr;
    for (int k = 0; k < 8; k++) begin
      if (!w_found && req[r_ptr + 3'(k)]) begin
        w_found  = 1'b1;
        w_winner = r_ptr + 3'(k);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (w_found) w_stateNext = BUSY;
      BUSY:    if (ready)   w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // Without the lock feature, LockEn is 0 and the port is read but has no effect.
  always_comb begin
    w_capture  = (r_state == IDLE) && w_found;
    w_complete = (r_state == BUSY) && ready;
    w_gntNext  = w_capture ? (8'h01 << w_winner) : 8'h00;
    w_lockHold = LockEn & lock;
    w_ptrNext  = w_lockHold ? r_sel : r_sel + 3'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr      <= 3'd0;
      r_gnt      <= 8'h00;
      r_sel      <= 3'd0;
      r_out      <= '0;
      r_outValid <= 1'b0;
      r_xferCnt  <= 16'h0000;
    end else begin
      r_gnt <= w_gntNext;
      if (w_capture) begin
        r_out      <= data[w_winner*WIDTH +: WIDTH];
        r_sel      <= w_winner;
        r_outValid <= 1'b1;
      end
      if (w_complete) begin
        r_outValid <= 1'b0;
        r_xferCnt  <= r_xferCnt + 16'd1;
        r_ptr      <= w_ptrNext;
      end
    end
  end

  assign gnt       = r_gnt;
  assign sel       = r_sel;
  assign out       = r_out;
  assign out_valid = r_outValid;
  assign xfer_cnt  = r_xferCnt;

endmodule

// File: tb/tb_arb8_16b.sv
// tb_arb8_16b: directed, self-checking bench for the arb8_16b round-robin arbiter.
// Lock expectations follow ARB8_LOCK_EN when it is defined for the whole build.
module tb_arb8_16b;
  localparam int WIDTH = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic [7:0]         req;
  logic [8*WIDTH-1:0] data;
  logic               lock;
  logic               ready;
  logic [7:0]         gnt;
  logic [2:0]         sel;
  logic [WIDTH-1:0]   out;
  logic               out_valid;
  logic [15:0]        xfer_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  arb8_16b #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .req(req), .data(data), .lock(lock), .ready(ready),
    .gnt(gnt), .sel(sel), .out(out), .out_valid(out_valid), .xfer_cnt(xfer_cnt)
  );

  task automatic applyStimulus(input logic [7:0] r, input logic l, input logic rd);
    req   = r;
    lock  = l;
    ready = rd;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One capture edge then one completion edge, with ready held high.
  task automatic doTransfer(input string tag, input logic [2:0] expSel, input logic [15:0] expCnt);
    @(negedge clk);
    checkOutput({tag, "_gnt"}, 64'(gnt), 64'(8'h01 << expSel));
    checkOutput({tag, "_sel"}, 64'(sel), 64'(expSel));
    checkOutput({tag, "_out"}, 64'(out), 64'(16'h1000 + 16'(expSel)));
    checkOutput({tag, "_vld"}, 64'(out_valid), 64'd1);
    @(negedge clk);
    checkOutput({tag, "_done"}, 64'({gnt, out_valid, xfer_cnt}), 64'({8'h00, 1'b0, expCnt}));
  endtask

  logic [2:0] lockSeq [4];

  initial begin
`ifdef ARB8_LOCK_EN
    lockSeq = '{3'd2, 3'd2, 3'd2, 3'd2};
`else
    lockSeq = '{3'd2, 3'd3, 3'd2, 3'd3};
`endif
    rst = 1'b1;
    applyStimulus(8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) data[i*WIDTH +: WIDTH] = 16'h1000 + 16'(i);
    repeat (2) @(negedge clk);
    checkOutput("rst_gnt", 64'(gnt), 64'h0);
    checkOutput("rst_sel", 64'(sel), 64'h0);
    checkOutput("rst_out", 64'(out), 64'h0);
    checkOutput("rst_vld", 64'(out_valid), 64'h0);
    checkOutput("rst_cnt", 64'(xfer_cnt), 64'h0);
    rst = 1'b0;

    // No requests: nothing is granted or counted.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkOutput($sformatf("idle_%0d", c), 64'({gnt, out_valid, xfer_cnt}), 64'h0);
    end

    // All requesting: 0..7 then wrap to 0, one word per 2 cycles.
    applyStimulus(8'hFF, 1'b0, 1'b1);
    for (int k = 0; k < 9; k++)
      doTransfer($sformatf("rr_%0d", k), 3'(k % 8), 16'(k + 1));
    applyStimulus(8'h00, 1'b0, 1'b0);

    // Single requester 5 with ready held off for 4 cycles.
    data[5*WIDTH +: WIDTH] = 16'hBEEF;
    applyStimulus(8'h20, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("hold_gnt", 64'(gnt), 64'h20);
    checkOutput("hold_sel", 64'(sel), 64'd5);
    checkOutput("hold_first", 64'({out_valid, out}), 64'({1'b1, 16'hBEEF}));
    applyStimulus(8'h00, 1'b0, 1'b0);
    data[5*WIDTH +: WIDTH] = 16'h1234;
    for (int c = 2; c <= 5; c++) begin
      @(negedge clk);
      checkOutput($sformatf("hold_%0d", c), 64'({gnt, out_valid, out}), 64'({8'h00, 1'b1, 16'hBEEF}));
    end
    applyStimulus(8'h00, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("hold_done", 64'({out_valid, xfer_cnt}), 64'({1'b0, 16'd10}));
    data[5*WIDTH +: WIDTH] = 16'h1005;

    // Pointer now at 6: requesters 0,5,6 -> 6 wins, then scan wraps to 0.
    applyStimulus(8'h61, 1'b0, 1'b1);
    doTransfer("ptr6", 3'd6, 16'd11);
    doTransfer("ptrwrap", 3'd0, 16'd12);
    applyStimulus(8'h00, 1'b0, 1'b0);

    // Asynchronous reset while a word is in flight.
    applyStimulus(8'h08, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("busy_pre", 64'({out_valid, sel}), 64'({1'b1, 3'd3}));
    #2 rst = 1'b1;
    #1 checkOutput("async_rst", 64'({gnt, sel, out, out_valid, xfer_cnt}), 64'h0);
    applyStimulus(8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Two requesters with lock high, then lock low.
    applyStimulus(8'h0C, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++)
      doTransfer($sformatf("lock1_%0d", k), lockSeq[k], 16'(k + 1));
    applyStimulus(8'h0C, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++)
      doTransfer($sformatf("lock0_%0d", k), (k % 2 == 0) ? 3'd2 : 3'd3, 16'(k + 5));
    applyStimulus(8'h00, 1'b0, 1'b0);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
